i2s_rx_scheduler: RTL

I2S_RX_SCHEDULER -- requirements
Module: i2s_rx_scheduler

---
 rtl/i2s_pkg.sv | 17 +
 rtl/sample_fifo.sv | 64 ++++++
 rtl/i2s_rx_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive scheduler: FSM encoding
// and the default word/frame geometry.
package i2s_pkg;

    localparam int DEFAULT_NUMBER_OF_BITS = 8;
    localparam int DEFAULT_WS_HALF_PERIOD = 32;
    localparam int DEFAULT_FIFO_DEPTH     = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EDGE,
        DELAY,
        SHIFT,
        PUSH
    } rx_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two synchronous FIFO with occupancy count and
// combinational head read.
module sample_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sample_fifo DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_en;
    logic             rd_en;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    always_comb begin
        wr_en    = push && (!full || pop);
        rd_en    = pop && !empty;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(wr_en) - LW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/i2s_rx_scheduler.sv
// I2S receiver: generates word select, captures one MSB-first word
// per half frame and queues {channel, word} in an output FIFO.
module i2s_rx_scheduler
    import i2s_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
    parameter int WS_HALF_PERIOD = DEFAULT_WS_HALF_PERIOD,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        data_in,
    output logic                        ws_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUMBER_OF_BITS-1:0]   out_data,
    output logic                        out_channel,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int N  = NUMBER_OF_BITS;
    localparam int CW = $clog2(WS_HALF_PERIOD);
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    if (N < 2) begin : g_bad_bits
        $error("NUMBER_OF_BITS must be at least 2");
    end
    if (WS_HALF_PERIOD < N + 3) begin : g_bad_period
        $error("WS_HALF_PERIOD must be at least NUMBER_OF_BITS+3");
    end

    rx_state_e       state_q, state_d;
    logic [CW-1:0]   ws_cnt_q, ws_cnt_d;
    logic            ws_out_q, ws_out_d;
    logic            prev_ws_q, prev_ws_d;
    logic            ch_q, ch_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            overflow_q, overflow_d;
    logic            ws_wrap;
    logic            ws_edge;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [N:0]      head;

    assign ws_out      = ws_out_q;
    assign overflow    = overflow_q;
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign out_channel = head[N];
    assign out_data    = head[N-1:0];

    always_comb begin
        ws_wrap = (ws_cnt_q == CW'(WS_HALF_PERIOD - 1));
        if (!enable) begin
            ws_cnt_d = '0;
            ws_out_d = 1'b0;
        end else begin
            ws_cnt_d = ws_wrap ? '0 : ws_cnt_q + CW'(1);
            ws_out_d = ws_wrap ? !ws_out_q : ws_out_q;
        end
        prev_ws_d = ws_out_d;
        // Edge seen on the toggling clock, so DELAY sits between E0 and E1.
        ws_edge = (ws_out_d != prev_ws_q);
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        push      = 1'b0;
        if (!enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_EDGE;
                WAIT_EDGE: begin
                    if (ws_edge) begin
                        state_d = DELAY;
                        ch_d    = ws_out_d;
                    end
                end
                DELAY: state_d = SHIFT;
                SHIFT: begin
                    shreg_d = {shreg_q[N-2:0], data_in};
                    if (bit_cnt_q == BW'(N - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = PUSH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                PUSH: begin
                    push    = 1'b1;
                    state_d = WAIT_EDGE;
                end
                default: state_d = IDLE;
            endcase
        end
        overflow_d = overflow_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ws_cnt_q   <= '0;
            ws_out_q   <= 1'b0;
            prev_ws_q  <= 1'b0;
            ch_q       <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ws_cnt_q   <= ws_cnt_d;
            ws_out_q   <= ws_out_d;
            prev_ws_q  <= prev_ws_d;
            ch_q       <= ch_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    sample_fifo #(
        .WIDTH (N + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({ch_q, shreg_q}),
        .pop       (pop),
        .pop_data  (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
